// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential stepping with wrap, clamped jumps,
// relative jumps with saturation, and a small call/return stack with sticky error flags.
module pc_sequencer #(
   parameter int AW  = 8,
   parameter int SD  = 4,
   parameter int SPW = $clog2(SD + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hlt_en,
   input  logic [AW-1:0] prog_len,
   input  logic [2:0]    op,
   input  logic          cond,
   input  logic [AW-1:0] imm,
   input  logic [AW-1:0] jAddr,
   input  logic [AW-1:0] rel,
   input  logic          clr_err,
   output logic [AW-1:0] Addr_instr,
   output logic [SPW-1:0] sp,
   output logic          wrap,
   output logic          stk_ovf,
   output logic          stk_unf
);

   localparam logic [2:0] OP_SEQ     = 3'b000;
   localparam logic [2:0] OP_JMP_IMM = 3'b001;
   localparam logic [2:0] OP_JMP_REG = 3'b010;
   localparam logic [2:0] OP_JRO     = 3'b011;
   localparam logic [2:0] OP_CALL    = 3'b100;
   localparam logic [2:0] OP_RET     = 3'b101;
   localparam logic [2:0] OP_RESTART = 3'b110;

   localparam int IW = (SD > 1) ? $clog2(SD) : 1;
   localparam logic [SPW-1:0] SP_FULL = SPW'(SD);

   logic [AW-1:0]  addr_reg, addr_next;
   logic [SPW-1:0] sp_reg, sp_next;
   logic           wrap_reg, wrap_next;
   logic           ovf_reg, ovf_next;
   logic           unf_reg, unf_next;

   logic [AW-1:0]  stack_mem [SD];
   logic           push;
   logic [IW-1:0]  push_idx, pop_idx;
   logic [AW-1:0]  pop_val;

   logic [AW-1:0]  last_line;
   logic [AW-1:0]  seq_addr;
   logic [2:0]     op_eff;
   logic           take_seq;
   logic signed [AW+1:0] jro_sum;

   function automatic logic [AW-1:0] clamp(input logic [AW-1:0] x, input logic [AW-1:0] l);
      return (x > l) ? l : x;
   endfunction

   always_comb begin
      last_line = (prog_len == '0) ? '0 : prog_len - 1'b1;
      seq_addr  = (addr_reg >= last_line) ? '0 : addr_reg + 1'b1;
      op_eff    = cond ? op : OP_SEQ;
      push_idx  = sp_reg[IW-1:0];
      pop_idx   = IW'(sp_reg - SPW'(1));
      pop_val   = stack_mem[pop_idx];
      // Two guard bits keep both negative results and overshoot above L representable
      jro_sum   = signed'({2'b00, addr_reg}) + signed'({{2{rel[AW-1]}}, rel});
   end

   always_comb begin
      addr_next = addr_reg;
      sp_next   = sp_reg;
      wrap_next = 1'b0;
      ovf_next  = ovf_reg;
      unf_next  = unf_reg;
      push      = 1'b0;
      take_seq  = 1'b0;
      if (!hlt_en) begin
         if (clr_err) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
         end
         case (op_eff)
            OP_JMP_IMM: addr_next = clamp(imm, last_line);
            OP_JMP_REG: addr_next = clamp(jAddr, last_line);
            OP_JRO: begin
               if (jro_sum[AW+1])
                  addr_next = '0;
               else if (jro_sum[AW:0] > {1'b0, last_line})
                  addr_next = last_line;
               else
                  addr_next = jro_sum[AW-1:0];
            end
            OP_CALL: begin
               if (sp_reg != SP_FULL) begin
                  push      = 1'b1;
                  sp_next   = sp_reg + 1'b1;
                  addr_next = clamp(imm, last_line);
               end else begin
                  ovf_next = 1'b1;
                  take_seq = 1'b1;
               end
            end
            OP_RET: begin
               if (sp_reg != '0) begin
                  sp_next   = sp_reg - 1'b1;
                  addr_next = clamp(pop_val, last_line);
               end else begin
                  unf_next = 1'b1;
                  take_seq = 1'b1;
               end
            end
            OP_RESTART: addr_next = '0;
            default:    take_seq = 1'b1;
         endcase
         if (take_seq) begin
            addr_next = seq_addr;
            wrap_next = (addr_reg >= last_line);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg <= '0;
         sp_reg   <= '0;
         wrap_reg <= 1'b0;
         ovf_reg  <= 1'b0;
         unf_reg  <= 1'b0;
      end else begin
         addr_reg <= addr_next;
         sp_reg   <= sp_next;
         wrap_reg <= wrap_next;
         ovf_reg  <= ovf_next;
         unf_reg  <= unf_next;
      end
   end

   // Stack contents need no reset; occupancy is tracked by sp_reg alone
   always_ff @(posedge clk) begin
      if (push)
         stack_mem[push_idx] <= seq_addr;
   end

   assign Addr_instr = addr_reg;
   assign sp         = sp_reg;
   assign wrap       = wrap_reg;
   assign stk_ovf    = ovf_reg;
   assign stk_unf    = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, asynchronous reset sequence,
// and randomized traffic against an integer-level reference model.
module tb_pc_sequencer;

   localparam int AW  = 8;
   localparam int SD  = 2;
   localparam int SPW = $clog2(SD + 1);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           hlt_en = 1'b0;
   logic [AW-1:0]  prog_len = '0;
   logic [2:0]     op = '0;
   logic           cond = 1'b0;
   logic [AW-1:0]  imm = '0;
   logic [AW-1:0]  jAddr = '0;
   logic [AW-1:0]  rel = '0;
   logic           clr_err = 1'b0;
   logic [AW-1:0]  Addr_instr;
   logic [SPW-1:0] sp;
   logic           wrap;
   logic           stk_ovf;
   logic           stk_unf;

   pc_sequencer #(.AW(AW), .SD(SD)) dut (
      .clk(clk), .rst(rst), .hlt_en(hlt_en), .prog_len(prog_len), .op(op),
      .cond(cond), .imm(imm), .jAddr(jAddr), .rel(rel), .clr_err(clr_err),
      .Addr_instr(Addr_instr), .sp(sp), .wrap(wrap), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_addr;
   int m_q[$];
   bit m_wrap, m_ovf, m_unf;

   typedef struct {
      int h, pl, o, c, im, ja, rl, cl;
      int ea, es, ew, eo, eu;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(int h, int pl, int o, int c, int im, int ja, int rl, int cl,
                               int ea, int es, int ew, int eo, int eu);
      vec_t v;
      v.h = h; v.pl = pl; v.o = o; v.c = c; v.im = im; v.ja = ja; v.rl = rl; v.cl = cl;
      v.ea = ea; v.es = es; v.ew = ew; v.eo = eo; v.eu = eu;
      return v;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 0;
      m_q.delete();
      m_wrap = 0; m_ovf = 0; m_unf = 0;
   endtask

   task automatic model_step(int h, int pl, int o, int c, int im, int ja, int rl, int cl);
      int lst, seqv, eo, r, t, v;
      bit do_seq;
      if (h != 0) begin
         m_wrap = 0;
         return;
      end
      lst    = (pl == 0) ? 0 : pl - 1;
      seqv   = (m_addr >= lst) ? 0 : m_addr + 1;
      eo     = (c != 0) ? o : 0;
      do_seq = 0;
      if (cl != 0) begin
         m_ovf = 0; m_unf = 0;
      end
      case (eo)
         1: m_addr = (im > lst) ? lst : im;
         2: m_addr = (ja > lst) ? lst : ja;
         3: begin
            r = (rl >= 128) ? rl - 256 : rl;
            t = m_addr + r;
            m_addr = (t < 0) ? 0 : ((t > lst) ? lst : t);
         end
         4: begin
            if (m_q.size() < SD) begin
               m_q.push_back(seqv);
               m_addr = (im > lst) ? lst : im;
            end else begin
               m_ovf = 1; do_seq = 1;
            end
         end
         5: begin
            if (m_q.size() > 0) begin
               v = m_q.pop_back();
               m_addr = (v > lst) ? lst : v;
            end else begin
               m_unf = 1; do_seq = 1;
            end
         end
         6: m_addr = 0;
         default: do_seq = 1;
      endcase
      if (do_seq) begin
         m_wrap = (m_addr >= lst);
         m_addr = seqv;
      end else begin
         m_wrap = 0;
      end
   endtask

   task automatic drive(int h, int pl, int o, int c, int im, int ja, int rl, int cl);
      hlt_en   = h[0];
      prog_len = AW'(pl);
      op       = 3'(o);
      cond     = c[0];
      imm      = AW'(im);
      jAddr    = AW'(ja);
      rel      = AW'(rl);
      clr_err  = cl[0];
   endtask

   task automatic step_model_chk(string tag, int h, int pl, int o, int c, int im, int ja, int rl, int cl);
      drive(h, pl, o, c, im, ja, rl, cl);
      @(posedge clk);
      model_step(h, pl, o, c, im, ja, rl, cl);
      #1;
      $display("%s h=%0d pl=%0d op=%0d c=%0d imm=%0d ja=%0d rel=%0d clr=%0d -> addr=%0d sp=%0d wrap=%0d ovf=%0d unf=%0d",
               tag, h, pl, o, c, im, ja, rl, cl, Addr_instr, sp, wrap, stk_ovf, stk_unf);
      chk({tag, " addr"}, int'(Addr_instr), m_addr);
      chk({tag, " sp"},   int'(sp), m_q.size());
      chk({tag, " wrap"}, int'(wrap), int'(m_wrap));
      chk({tag, " ovf"},  int'(stk_ovf), int'(m_ovf));
      chk({tag, " unf"},  int'(stk_unf), int'(m_unf));
   endtask

   initial begin
      // Directed vectors: h, plen, op, cond, imm, jAddr, rel, clr -> addr, sp, wrap, ovf, unf
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0,    1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0,    2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0,    3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0,    0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0,    1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 1, 1, 3, 0, 0, 0,   3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 3, 1, 0, 0, 248, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 1, 1, 3, 0, 0, 0,   3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 3, 1, 0, 0, 100, 0, 14, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 1, 1, 3, 0, 0, 0,   3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 2, 1, 0, 200, 0, 0, 14, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 1, 1, 5, 0, 0, 0,   5, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 4, 1, 9, 0, 0, 0,   9, 1, 0, 0, 0));
      vecs.push_back(mk(0, 15, 4, 1, 12, 0, 0, 0,  12, 2, 0, 0, 0));
      vecs.push_back(mk(0, 15, 4, 1, 1, 0, 0, 0,   13, 2, 0, 1, 0));
      vecs.push_back(mk(0, 15, 5, 1, 0, 0, 0, 0,   10, 1, 0, 1, 0));
      vecs.push_back(mk(0, 15, 5, 1, 0, 0, 0, 0,   6, 0, 0, 1, 0));
      vecs.push_back(mk(0, 15, 5, 1, 0, 0, 0, 0,   7, 0, 0, 1, 1));
      vecs.push_back(mk(0, 15, 0, 1, 0, 0, 0, 1,   8, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 1, 1, 6, 0, 0, 0,   6, 0, 0, 0, 0));
      vecs.push_back(mk(1, 15, 1, 1, 2, 0, 0, 0,   6, 0, 0, 0, 0));
      vecs.push_back(mk(1, 15, 1, 1, 2, 0, 0, 0,   6, 0, 0, 0, 0));
      vecs.push_back(mk(1, 15, 1, 1, 2, 0, 0, 0,   6, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 1, 1, 2, 0, 0, 0,   2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 4, 0, 9, 0, 0, 0,   3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 15, 5, 1, 0, 0, 0, 0,   4, 0, 0, 0, 1));
      vecs.push_back(mk(0, 15, 5, 1, 0, 0, 0, 1,   5, 0, 0, 0, 1));
      vecs.push_back(mk(1, 15, 0, 1, 0, 0, 0, 1,   5, 0, 0, 0, 1));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0,    0, 0, 1, 0, 1));
      vecs.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,    0, 0, 1, 0, 1));
      vecs.push_back(mk(0, 15, 1, 1, 7, 0, 0, 0,   7, 0, 0, 0, 1));
      vecs.push_back(mk(0, 15, 3, 1, 0, 0, 0, 0,   7, 0, 0, 0, 1));
      vecs.push_back(mk(0, 15, 7, 1, 3, 0, 0, 0,   8, 0, 0, 0, 1));
      vecs.push_back(mk(0, 15, 6, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1));

      model_reset();
      drive(0, 4, 0, 1, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset addr", int'(Addr_instr), 0);
      chk("reset sp",   int'(sp), 0);
      chk("reset wrap", int'(wrap), 0);
      chk("reset ovf",  int'(stk_ovf), 0);
      chk("reset unf",  int'(stk_unf), 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].h, vecs[i].pl, vecs[i].o, vecs[i].c, vecs[i].im, vecs[i].ja, vecs[i].rl, vecs[i].cl);
         @(posedge clk);
         model_step(vecs[i].h, vecs[i].pl, vecs[i].o, vecs[i].c, vecs[i].im, vecs[i].ja, vecs[i].rl, vecs[i].cl);
         #1;
         $display("vec %0d op=%0d -> addr=%0d sp=%0d wrap=%0d ovf=%0d unf=%0d",
                  i, vecs[i].o, Addr_instr, sp, wrap, stk_ovf, stk_unf);
         chk($sformatf("vec%0d addr", i), int'(Addr_instr), vecs[i].ea);
         chk($sformatf("vec%0d sp", i),   int'(sp), vecs[i].es);
         chk($sformatf("vec%0d wrap", i), int'(wrap), vecs[i].ew);
         chk($sformatf("vec%0d ovf", i),  int'(stk_ovf), vecs[i].eo);
         chk($sformatf("vec%0d unf", i),  int'(stk_unf), vecs[i].eu);
      end

      // Asynchronous reset while stalled with a full stack at address 9
      step_model_chk("pre_rst call3", 0, 15, 4, 1, 3, 0, 0, 0);
      step_model_chk("pre_rst call9", 0, 15, 4, 1, 9, 0, 0, 0);
      chk("pre_rst addr", int'(Addr_instr), 9);
      chk("pre_rst sp",   int'(sp), 2);
      hlt_en = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      $display("async rst -> addr=%0d sp=%0d wrap=%0d ovf=%0d unf=%0d", Addr_instr, sp, wrap, stk_ovf, stk_unf);
      chk("async addr", int'(Addr_instr), 0);
      chk("async sp",   int'(sp), 0);
      chk("async wrap", int'(wrap), 0);
      chk("async ovf",  int'(stk_ovf), 0);
      chk("async unf",  int'(stk_unf), 0);
      model_reset();
      hlt_en = 1'b0;
      @(posedge clk);
      #1;
      chk("rst hold addr", int'(Addr_instr), 0);
      #2;
      rst = 1'b0;
      step_model_chk("post_rst seq", 0, 15, 0, 1, 0, 0, 0, 0);
      chk("post_rst first update", int'(Addr_instr), 1);

      // Randomized traffic against the reference model
      begin
         int pl;
         pl = 10;
         for (int k = 0; k < 400; k++) begin
            int h, o, c, im, ja, rl, cl;
            if ($urandom_range(0, 9) == 0) pl = $urandom_range(0, 20);
            h  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            o  = $urandom_range(0, 7);
            c  = ($urandom_range(0, 4) == 0) ? 0 : 1;
            im = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
            ja = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
            rl = $urandom_range(0, 255);
            cl = ($urandom_range(0, 9) == 0) ? 1 : 0;
            step_model_chk($sformatf("rnd%0d", k), h, pl, o, c, im, ja, rl, cl);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
